// File: rtl/multicycle_seq_ctrl.sv
// rtl/multicycle_seq_ctrl.sv - per-instruction-class multi-cycle sequencer with memory handshake and retire counter
module multicycle_seq_ctrl #(
    parameter int FETCH_CYC   = 1,
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             run,
    input  logic             halt_req,
    input  logic             is_load,
    input  logic             is_store,
    input  logic             is_branch,
    input  logic             reg_wr_in,
    input  logic             mem_ack,
    output logic             inst_ld,
    output logic             pc_en,
    output logic             reg_we,
    output logic             mem_rd,
    output logic             mem_wr,
    output logic             err,
    output logic [2:0]       state,
    output logic [CNT_W-1:0] retired
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_HALT   = 3'd6
    } state_t;

    localparam int FW = (FETCH_CYC > 1) ? $clog2(FETCH_CYC) : 1;
    localparam int WW = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
    localparam logic [FW-1:0] FETCH_LAST = FW'(FETCH_CYC - 1);
    localparam logic [FW-1:0] FETCH_PRE  = FW'(FETCH_CYC - 2);
    localparam logic [WW-1:0] WAIT_LAST  = WW'((MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0);
    localparam bit            TIMEOUT_EN = (MEM_TIMEOUT > 0);
    localparam bit            FETCH_ONE  = (FETCH_CYC == 1);

    state_t        st;
    state_t        ret_state;
    logic          cls_branch;
    logic          cls_load;
    logic          cls_store;
    logic          cls_wr;
    logic [FW-1:0] fetch_cnt;
    logic [WW-1:0] wait_cnt;
    logic          pc_en_q;
    logic          store_done;
    logic          retire;

    assign state = st;

    // A store completes on the ack cycle itself, so its PC advance cannot wait a register stage.
    assign store_done = (st == S_MEM) && cls_store && mem_ack;
    assign retire     = ((st == S_EXEC) && cls_branch) || (st == S_WB) || store_done;
    assign pc_en      = pc_en_q | store_done;

    always_comb begin
        ret_state = S_IDLE;
        if (halt_req)
            ret_state = S_HALT;
        else if (run)
            ret_state = S_FETCH;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            st         <= S_IDLE;
            cls_branch <= 1'b0;
            cls_load   <= 1'b0;
            cls_store  <= 1'b0;
            cls_wr     <= 1'b0;
            fetch_cnt  <= '0;
            wait_cnt   <= '0;
            inst_ld    <= 1'b0;
            pc_en_q    <= 1'b0;
            reg_we     <= 1'b0;
            mem_rd     <= 1'b0;
            mem_wr     <= 1'b0;
            err        <= 1'b0;
            retired    <= '0;
        end else begin
            inst_ld <= 1'b0;
            pc_en_q <= 1'b0;
            reg_we  <= 1'b0;

            case (st)
                S_IDLE: begin
                    if (run) begin
                        st        <= S_FETCH;
                        fetch_cnt <= '0;
                        inst_ld   <= FETCH_ONE;
                    end
                end
                S_FETCH: begin
                    if (fetch_cnt == FETCH_LAST) begin
                        st <= S_DECODE;
                    end else begin
                        fetch_cnt <= fetch_cnt + 1'b1;
                        inst_ld   <= (fetch_cnt == FETCH_PRE);
                    end
                end
                S_DECODE: begin
                    cls_branch <= is_branch;
                    cls_load   <= is_load & ~is_branch;
                    cls_store  <= is_store & ~is_branch & ~is_load;
                    cls_wr     <= reg_wr_in;
                    pc_en_q    <= is_branch;
                    st         <= S_EXEC;
                end
                S_EXEC: begin
                    if (!cls_branch) begin
                        if (cls_load || cls_store) begin
                            st       <= S_MEM;
                            wait_cnt <= '0;
                            mem_rd   <= cls_load;
                            mem_wr   <= cls_store;
                        end else begin
                            st      <= S_WB;
                            reg_we  <= cls_wr;
                            pc_en_q <= 1'b1;
                        end
                    end
                end
                S_MEM: begin
                    if (mem_ack) begin
                        mem_rd <= 1'b0;
                        mem_wr <= 1'b0;
                        if (cls_load) begin
                            st      <= S_WB;
                            reg_we  <= cls_wr;
                            pc_en_q <= 1'b1;
                        end
                    end else if (TIMEOUT_EN && (wait_cnt == WAIT_LAST)) begin
                        st     <= S_HALT;
                        err    <= 1'b1;
                        mem_rd <= 1'b0;
                        mem_wr <= 1'b0;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                S_WB: begin
                end
                S_HALT: begin
                end
                default: st <= S_IDLE;
            endcase

            // Retire overrides whatever the state arm chose for the next state.
            if (retire) begin
                retired   <= retired + 1'b1;
                st        <= ret_state;
                fetch_cnt <= '0;
                inst_ld   <= (ret_state == S_FETCH) && FETCH_ONE;
            end
        end
    end

endmodule

// File: tb/tb_multicycle_seq_ctrl.sv
// tb/tb_multicycle_seq_ctrl.sv - directed table and corner-case checks for multicycle_seq_ctrl
module tb_multicycle_seq_ctrl;

    logic clk = 1'b0;
    logic rst_a, rst_b;
    logic run, halt_req, is_load, is_store, is_branch, reg_wr_in, mem_ack;

    logic       a_inst_ld, a_pc_en, a_reg_we, a_mem_rd, a_mem_wr, a_err;
    logic [2:0] a_state;
    logic [3:0] a_retired;

    logic        b_inst_ld, b_pc_en, b_reg_we, b_mem_rd, b_mem_wr, b_err;
    logic [2:0]  b_state;
    logic [31:0] b_retired;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    multicycle_seq_ctrl #(.FETCH_CYC(1), .MEM_TIMEOUT(4), .CNT_W(4)) dut_a (
        .clk(clk), .reset(rst_a), .run(run), .halt_req(halt_req),
        .is_load(is_load), .is_store(is_store), .is_branch(is_branch),
        .reg_wr_in(reg_wr_in), .mem_ack(mem_ack),
        .inst_ld(a_inst_ld), .pc_en(a_pc_en), .reg_we(a_reg_we),
        .mem_rd(a_mem_rd), .mem_wr(a_mem_wr), .err(a_err),
        .state(a_state), .retired(a_retired)
    );

    multicycle_seq_ctrl #(.FETCH_CYC(3), .MEM_TIMEOUT(16), .CNT_W(32)) dut_b (
        .clk(clk), .reset(rst_b), .run(run), .halt_req(halt_req),
        .is_load(is_load), .is_store(is_store), .is_branch(is_branch),
        .reg_wr_in(reg_wr_in), .mem_ack(mem_ack),
        .inst_ld(b_inst_ld), .pc_en(b_pc_en), .reg_we(b_reg_we),
        .mem_rd(b_mem_rd), .mem_wr(b_mem_wr), .err(b_err),
        .state(b_state), .retired(b_retired)
    );

    // in = {run, halt_req, is_load, is_store, is_branch, reg_wr_in, mem_ack}
    // out = {inst_ld, pc_en, reg_we, mem_rd, mem_wr}
    typedef struct {
        logic [6:0] in;
        logic [2:0] e_state;
        logic [4:0] e_out;
    } vec_t;

    localparam int NV = 22;
    vec_t vt[NV];

    function automatic vec_t mk(input logic [6:0] i, input logic [2:0] s, input logic [4:0] o);
        vec_t v;
        v.in = i;
        v.e_state = s;
        v.e_out = o;
        return v;
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic [6:0] v);
        {run, halt_req, is_load, is_store, is_branch, reg_wr_in, mem_ack} = v;
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic reset_a();
        rst_a = 1'b1;
        step();
        rst_a = 1'b0;
    endtask

    task automatic wait_retires(input int n);
        int  c = 0;
        bit  done = 1'b0;
        for (int k = 0; k < 200 && !done; k++) begin
            #1;
            if (a_pc_en) c++;
            if (c == n) done = 1'b1;
            step();
        end
        if (!done) check("retire_wait_bound", 32'(c), 32'(n));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        vt[0]  = mk(7'b1000000, 3'd0, 5'b00000);
        vt[1]  = mk(7'b1000000, 3'd1, 5'b10000);
        vt[2]  = mk(7'b1000010, 3'd2, 5'b00000);
        vt[3]  = mk(7'b1000000, 3'd3, 5'b00000);
        vt[4]  = mk(7'b1000000, 3'd5, 5'b01100);
        vt[5]  = mk(7'b1000000, 3'd1, 5'b10000);
        vt[6]  = mk(7'b1010110, 3'd2, 5'b00000);
        vt[7]  = mk(7'b0000000, 3'd3, 5'b01000);
        vt[8]  = mk(7'b0000000, 3'd0, 5'b00000);
        vt[9]  = mk(7'b1000000, 3'd0, 5'b00000);
        vt[10] = mk(7'b1000000, 3'd1, 5'b10000);
        vt[11] = mk(7'b1001000, 3'd2, 5'b00000);
        vt[12] = mk(7'b1000001, 3'd3, 5'b00000);
        vt[13] = mk(7'b1000001, 3'd4, 5'b01001);
        vt[14] = mk(7'b1000000, 3'd1, 5'b10000);
        vt[15] = mk(7'b1011010, 3'd2, 5'b00000);
        vt[16] = mk(7'b1000001, 3'd3, 5'b00000);
        vt[17] = mk(7'b1000000, 3'd4, 5'b00010);
        vt[18] = mk(7'b1000001, 3'd4, 5'b00010);
        vt[19] = mk(7'b1100000, 3'd5, 5'b01100);
        vt[20] = mk(7'b1000000, 3'd6, 5'b00000);
        vt[21] = mk(7'b1000000, 3'd6, 5'b00000);

        rst_a = 1'b1;
        rst_b = 1'b1;
        drive(7'b0000000);
        step();
        step();
        #1;
        check("reset state", 32'(a_state), 0);
        check("reset strobes", 32'({a_inst_ld, a_pc_en, a_reg_we, a_mem_rd, a_mem_wr}), 0);
        check("reset err", 32'(a_err), 0);
        check("reset retired", 32'(a_retired), 0);
        @(negedge clk);
        rst_a = 1'b0;

        // ALU, branch (with load also asserted), store, load (with store also asserted), halt
        for (int i = 0; i < NV; i++) begin
            drive(vt[i].in);
            #1;
            check($sformatf("row%0d state", i), 32'(a_state), 32'(vt[i].e_state));
            check($sformatf("row%0d strobes", i),
                  32'({a_inst_ld, a_pc_en, a_reg_we, a_mem_rd, a_mem_wr}), 32'(vt[i].e_out));
            check($sformatf("row%0d err", i), 32'(a_err), 0);
            step();
        end
        check("table retired", 32'(a_retired), 4);

        // memory timeout: four un-acked MEM cycles then HALT with err, no retire
        reset_a();
        drive(7'b1010000);
        begin
            int rd_cnt = 0, pc_cnt = 0, mem_cnt = 0;
            for (int k = 0; k < 15; k++) begin
                #1;
                if (a_mem_rd) rd_cnt++;
                if (a_pc_en) pc_cnt++;
                if (a_state == 3'd4) mem_cnt++;
                step();
            end
            #1;
            check("timeout mem_rd cycles", 32'(rd_cnt), 4);
            check("timeout mem cycles", 32'(mem_cnt), 4);
            check("timeout pc_en pulses", 32'(pc_cnt), 0);
            check("timeout state", 32'(a_state), 6);
            check("timeout err", 32'(a_err), 1);
            check("timeout retired", 32'(a_retired), 0);
            #1;
            rst_a = 1'b1;
            #1;
            check("async reset clears err", 32'(a_err), 0);
            check("async reset from halt state", 32'(a_state), 0);
            step();
            rst_a = 1'b0;
        end

        // async reset mid-MEM, between clock edges
        drive(7'b1010000);
        for (int k = 0; k < 10 && a_state != 3'd4; k++) step();
        #1;
        check("reach MEM", 32'(a_state), 4);
        check("mem_rd before reset", 32'(a_mem_rd), 1);
        #1;
        rst_a = 1'b1;
        #1;
        check("midmem reset state", 32'(a_state), 0);
        check("midmem reset strobes", 32'({a_inst_ld, a_pc_en, a_reg_we, a_mem_rd, a_mem_wr}), 0);
        check("midmem reset err", 32'(a_err), 0);
        step();
        #1;
        check("held reset strobes", 32'({a_pc_en, a_reg_we, a_mem_rd, a_mem_wr}), 0);
        @(negedge clk);
        rst_a = 1'b0;

        // retired counter wraps at 2^4, then halt_req at a branch retire
        drive(7'b1000100);
        wait_retires(15);
        #1;
        check("retired at max", 32'(a_retired), 15);
        wait_retires(1);
        #1;
        check("retired wraps", 32'(a_retired), 0);
        drive(7'b1100100);
        wait_retires(1);
        #1;
        check("halt at branch retire", 32'(a_state), 6);
        check("retired after halt", 32'(a_retired), 1);

        // FETCH_CYC=3 load, ack on the third MEM cycle
        rst_a = 1'b1;
        step();
        rst_b = 1'b0;
        drive(7'b1010010);
        begin
            int total = 0, rd_cnt = 0, wr_cnt = 0, mem_seen = 0, ild_cnt = 0, ild_at = -1;
            bit done = 1'b0, we_with_pc = 1'b0;
            for (int k = 0; k < 30; k++) begin
                mem_ack = (b_state == 3'd4) && (mem_seen == 2);
                #1;
                if (b_state != 3'd0 && !done) begin
                    total++;
                    if (b_mem_rd) rd_cnt++;
                    if (b_mem_wr) wr_cnt++;
                    if (b_state == 3'd4) mem_seen++;
                    if (b_inst_ld) begin
                        ild_cnt++;
                        ild_at = total - 1;
                    end
                    if (b_pc_en) begin
                        done = 1'b1;
                        we_with_pc = b_reg_we;
                    end
                    run = 1'b0;
                end
                step();
            end
            #1;
            check("slow load total cycles", 32'(total), 9);
            check("slow load mem_rd cycles", 32'(rd_cnt), 3);
            check("slow load mem_wr cycles", 32'(wr_cnt), 0);
            check("slow load inst_ld count", 32'(ild_cnt), 1);
            check("slow load inst_ld position", 32'(ild_at), 2);
            check("slow load reg_we with pc_en", 32'(we_with_pc), 1);
            check("slow load idle after retire", 32'(b_state), 0);
            check("slow load retired", b_retired, 1);
            check("slow load err", 32'(b_err), 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
